// File: rtl/cla_sum_capture.sv
// Capture stage behind CLA_64: aligns issue strobes to the adder latency and
// buffers {crout,sum} results in a small first-word-fall-through FIFO with drop accounting.
module cla_sum_capture #(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [WIDTH-1:0] sum,
  input  logic             crout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count
);

  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] sum;
  } entry_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [LATENCY:1] vld_pipe;
  logic             cap;
  entry_t           mem [DEPTH];
  entry_t           head;
  logic [AW-1:0]    wptr, rptr;
  logic             pop, accept, drop;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= issue_valid;
      for (int i = 2; i <= LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign cap = vld_pipe[LATENCY];

  assign empty     = (level == '0);
  assign full      = (level == DEPTH_L);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign accept    = cap && (!full || pop);
  assign drop      = cap && full && !pop;

  always_ff @(posedge clock) begin
    if (!reset && accept) mem[wptr] <= '{carry: crout, sum: sum};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      case ({accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
    end
  end

  assign head      = mem[rptr];
  assign out_sum   = empty ? '0 : head.sum;
  assign out_carry = empty ? 1'b0 : head.carry;

endmodule
